// File: rtl/fx3_pkg.sv
// Shared FX3 slave-FIFO definitions: master mode encodings,
// checker state type and default datapath widths.
package fx3_pkg;

  localparam logic [2:0] MODE_PARTIAL    = 3'b000;
  localparam logic [2:0] MODE_ZLP        = 3'b001;
  localparam logic [2:0] MODE_STREAM_IN  = 3'b010;
  localparam logic [2:0] MODE_STREAM_OUT = 3'b011;

  localparam int DATA_W_DEF = 32;
  localparam int ERR_W_DEF  = 16;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_SEEK     = 2'd1,
    ST_LOCK     = 2'd2
  } chk_state_e;

  function automatic logic is_stream_out(input logic [2:0] m);
    return m == MODE_STREAM_OUT;
  endfunction

endpackage

// File: rtl/fx3_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones
// so a long error storm never wraps back to a clean-looking value.
module fx3_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  // count up, stick at all-ones, clear wins over increment
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/fx3_stream_out_checker.sv
// Stream_out read-path pattern checker (incrementing counter).
// Optional burst-length check: define FX3_CHK_BURST_LEN_EN.
module fx3_stream_out_checker
  import fx3_pkg::*;
#(
  parameter int DATA_W        = DATA_W_DEF,
  parameter int ERR_W         = ERR_W_DEF,
  parameter int RESYNC_THRESH = 4,
  parameter int INCR          = 1
`ifdef FX3_CHK_BURST_LEN_EN
  ,
  parameter int EXP_BURST_LEN = 4
`endif
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        mode,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_valid,
  input  logic              burst_end,
  input  logic              clear,
  output logic              locked,
  output logic              err_flag,
  output logic [ERR_W-1:0]  err_count,
  output logic [31:0]       word_count,
  output logic [15:0]       burst_count,
  output logic [DATA_W-1:0] first_err_got,
  output logic [DATA_W-1:0] first_err_exp
`ifdef FX3_CHK_BURST_LEN_EN
  ,
  output logic [ERR_W-1:0]  len_err_count
`endif
);

  localparam int RUN_W = $clog2(RESYNC_THRESH + 1);

  chk_state_e state_q;
  chk_state_e state_d;

  logic [DATA_W-1:0] exp_q;
  logic [RUN_W-1:0]  run_q;

  logic en;
  logic hit;
  logic chk_ev;
  logic seed_ev;
  logic mis_ev;
  logic hit_ev;
  logic resync;
  logic len_ev;

  assign en      = is_stream_out(mode);
  assign hit     = (rd_data == exp_q);
  assign chk_ev  = en && rd_valid && (state_q == ST_LOCK);
  assign seed_ev = en && rd_valid && (state_q == ST_SEEK);
  assign mis_ev  = chk_ev && !hit;
  assign hit_ev  = chk_ev && hit;
  // a same-cycle clear zeroes the run, so it cannot trip a resync
  assign resync  = mis_ev && !clear &&
                   (run_q == RUN_W'(RESYNC_THRESH - 1));

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_DISABLED;
    end else begin
      state_q <= state_d;
    end
  end

  // next state: leaving Stream_out always wins
  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = ST_DISABLED;
    end else begin
      case (state_q)
        ST_DISABLED: state_d = ST_SEEK;
        ST_SEEK:     if (rd_valid) state_d = ST_LOCK;
        ST_LOCK:     if (resync) state_d = ST_SEEK;
        default:     state_d = ST_DISABLED;
      endcase
    end
  end

  // registered lock indicator tracks the next state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      locked <= 1'b0;
    end else begin
      locked <= (state_d == ST_LOCK);
    end
  end

  // expected value re-anchors on every accepted word
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exp_q <= '0;
    end else if (seed_ev || chk_ev) begin
      exp_q <= rd_data + DATA_W'(INCR);
    end
  end

  // consecutive-mismatch run length
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q <= '0;
    end else if (clear || seed_ev || hit_ev) begin
      run_q <= '0;
    end else if (mis_ev) begin
      run_q <= resync ? '0 : run_q + RUN_W'(1);
    end
  end

  // word and burst statistics
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_count  <= '0;
      burst_count <= '0;
    end else if (clear) begin
      word_count  <= '0;
      burst_count <= '0;
    end else begin
      if (hit_ev) word_count <= word_count + 32'd1;
      if (en && burst_end) burst_count <= burst_count + 16'd1;
    end
  end

  // sticky error flag and first-mismatch snapshot
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_flag      <= 1'b0;
      first_err_got <= '0;
      first_err_exp <= '0;
    end else if (clear) begin
      err_flag      <= 1'b0;
      first_err_got <= '0;
      first_err_exp <= '0;
    end else begin
      if (mis_ev || len_ev) err_flag <= 1'b1;
      if (mis_ev && !err_flag) begin
        first_err_got <= rd_data;
        first_err_exp <= exp_q;
      end
    end
  end

  fx3_sat_counter #(
    .W(ERR_W)
  ) u_err_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (clear),
    .inc    (mis_ev),
    .count  (err_count)
  );

`ifdef FX3_CHK_BURST_LEN_EN
  logic [15:0] blen_q;
  logic [15:0] blen_now;

  // the word coinciding with burst_end belongs to that burst
  assign blen_now = blen_q + {15'd0, chk_ev};
  assign len_ev   = en && burst_end &&
                    (blen_now != 16'(EXP_BURST_LEN));

  // per-burst word counter; a mode change abandons the burst
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blen_q <= '0;
    end else if (!en || burst_end) begin
      blen_q <= '0;
    end else if (chk_ev) begin
      blen_q <= blen_now;
    end
  end

  fx3_sat_counter #(
    .W(ERR_W)
  ) u_len_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (clear),
    .inc    (len_ev),
    .count  (len_err_count)
  );
`else
  assign len_ev = 1'b0;
`endif

endmodule

// File: tb/tb_fx3_stream_out_checker.sv
// Scoreboard bench for fx3_stream_out_checker.
// Error counter narrowed to 8 bits so saturation is reachable quickly.
module tb_fx3_stream_out_checker;

  localparam int EW = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [2:0]    mode = 3'b000;
  logic [31:0]   rd_data = '0;
  logic          rd_valid = 1'b0;
  logic          burst_end = 1'b0;
  logic          clear = 1'b0;
  logic          locked;
  logic          err_flag;
  logic [EW-1:0] err_count;
  logic [31:0]   word_count;
  logic [15:0]   burst_count;
  logic [31:0]   first_err_got;
  logic [31:0]   first_err_exp;
`ifdef FX3_CHK_BURST_LEN_EN
  logic [EW-1:0] len_err_count;
`endif

  fx3_stream_out_checker #(
    .DATA_W(32),
    .ERR_W (EW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .mode         (mode),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .burst_end    (burst_end),
    .clear        (clear),
    .locked       (locked),
    .err_flag     (err_flag),
    .err_count    (err_count),
    .word_count   (word_count),
    .burst_count  (burst_count),
    .first_err_got(first_err_got),
    .first_err_exp(first_err_exp)
`ifdef FX3_CHK_BURST_LEN_EN
    ,
    .len_err_count(len_err_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic        lk;
    logic        ef;
    logic [31:0] ec;
    logic [31:0] wc;
    logic [31:0] bc;
    logic [31:0] fg;
    logic [31:0] fe;
    logic [31:0] le;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] d;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %h want %h (cycle %0d)",
               nm, act, want, cyc);
    end
  endtask

  // monitor: compare every expectation due at this cycle
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      cmp("locked", 32'(locked), 32'(e.lk));
      cmp("err_flag", 32'(err_flag), 32'(e.ef));
      cmp("err_count", 32'(err_count), e.ec);
      cmp("word_count", word_count, e.wc);
      cmp("burst_count", 32'(burst_count), e.bc);
      cmp("first_err_got", first_err_got, e.fg);
      cmp("first_err_exp", first_err_exp, e.fe);
`ifdef FX3_CHK_BURST_LEN_EN
      cmp("len_err_count", 32'(len_err_count), e.le);
`endif
    end
  end

  // expectation for the state after the next driven cycle
  task automatic push(input logic lk, input logic ef,
                      input logic [31:0] ec, input logic [31:0] wc,
                      input logic [31:0] bc, input logic [31:0] fg,
                      input logic [31:0] fe, input logic [31:0] le);
    exp_t x;
    x.cyc = cyc + 1;
    x.lk = lk; x.ef = ef; x.ec = ec; x.wc = wc;
    x.bc = bc; x.fg = fg; x.fe = fe; x.le = le;
    sb.push_back(x);
  endtask

  task automatic drive(input logic v, input logic [31:0] dat,
                       input logic be, input logic cl,
                       input logic [2:0] m);
    mode = m; rd_valid = v; rd_data = dat;
    burst_end = be; clear = cl;
    @(posedge clk); #1;
    rd_valid = 1'b0; burst_end = 1'b0; clear = 1'b0;
  endtask

  task automatic word(input logic [31:0] dat);
    drive(1'b1, dat, 1'b0, 1'b0, 3'b011);
  endtask

  task automatic toggle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 3'b000);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 3'b011);
  endtask

  task automatic do_clear();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 3'b011);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    push(0, 0, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 3'b000);

    // 1: plain counter stream
    push(0, 0, 0, 0, 0, 0, 0, 0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 3'b011);
    push(1, 0, 0, 0, 0, 0, 0, 0);
    word(32'h10);
    for (int i = 32'h11; i < 32'h1F; i++) word(32'(i));
    push(1, 0, 0, 15, 0, 0, 0, 0);
    word(32'h1F);
    push(1, 0, 0, 0, 0, 0, 0, 0);
    do_clear();

    // 2: one dropped word; mode change ignores words
    push(0, 0, 0, 0, 0, 0, 0, 0);
    drive(1'b1, 32'h55, 1'b0, 1'b0, 3'b000);
    push(0, 0, 0, 0, 0, 0, 0, 0);
    drive(1'b1, 32'h66, 1'b0, 1'b0, 3'b011);
    push(1, 0, 0, 0, 0, 0, 0, 0);
    word(32'h100);
    word(32'h101);
    push(1, 1, 1, 1, 0, 32'h103, 32'h102, 0);
    word(32'h103);
    push(1, 1, 1, 2, 1, 32'h103, 32'h102, 1);
    drive(1'b1, 32'h104, 1'b1, 1'b0, 3'b011);
    push(1, 0, 0, 0, 0, 0, 0, 0);
    do_clear();

    // 3: wrap; burst_end while disabled is not counted
    push(0, 0, 0, 0, 0, 0, 0, 0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 3'b000);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 3'b011);
    word(32'hFFFF_FFFE);
    word(32'hFFFF_FFFF);
    word(32'h0);
    push(1, 0, 0, 3, 0, 0, 0, 0);
    word(32'h1);

    // 4: four mismatches drop lock, next word re-seeds
    do_clear();
    toggle();
    word(32'h0);
    word(32'h50);
    word(32'h60);
    push(1, 1, 3, 0, 0, 32'h50, 32'h1, 0);
    word(32'h70);
    push(0, 1, 4, 0, 0, 32'h50, 32'h1, 0);
    word(32'h80);
    push(1, 1, 4, 0, 0, 32'h50, 32'h1, 0);
    word(32'h200);
    push(1, 1, 4, 1, 0, 32'h50, 32'h1, 0);
    word(32'h201);

    // 5: saturation, then clear with a same-cycle mismatch
    do_clear();
    toggle();
    d = 32'h1000;
    for (int g = 0; g < 63; g++) begin
      word(d);
      for (int k = 0; k < 4; k++) begin
        d = d + 2;
        word(d);
      end
    end
    d = d + 2; word(d);
    d = d + 2; word(d);
    d = d + 2;
    push(1, 1, 32'hFE, 0, 0, 32'h1002, 32'h1001, 0);
    word(d);
    d = d + 1; word(d);
    d = d + 2;
    push(1, 1, 32'hFF, 1, 0, 32'h1002, 32'h1001, 0);
    word(d);
    d = d + 1; word(d);
    d = d + 2; word(d);
    d = d + 2;
    push(1, 1, 32'hFF, 2, 0, 32'h1002, 32'h1001, 0);
    word(d);
    d = d + 2;
    push(1, 0, 0, 0, 0, 0, 0, 0);
    drive(1'b1, d, 1'b0, 1'b1, 3'b011);

`ifdef FX3_CHK_BURST_LEN_EN
    // 6: burst lengths 4,4,3
    toggle();
    d = 32'h3000;
    word(d);
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < ((b == 2) ? 3 : 4); k++) begin
        d = d + 1;
        if (b == 0 && k == 3)
          push(1, 0, 0, 4, 1, 0, 0, 0);
        if (b == 2 && k == 2)
          push(1, 1, 0, 11, 3, 0, 0, 1);
        drive(1'b1, d, (k == ((b == 2) ? 2 : 3)), 1'b0, 3'b011);
      end
    end
`endif

    // asynchronous reset while locked
    word(32'h7000);
    word(32'h7001);
    reset_n = 1'b0;
    push(0, 0, 0, 0, 0, 0, 0, 0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 3'b011);
    reset_n = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
